// File: rtl/frame_buffer.sv
// Pixel frame buffer: registered 1-cycle read port for the VGA stage, FIFO-fed write port.
// Optional full-frame clear engine compiled in with `define FB_CLEAR_EN.
module frame_buffer #(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] iColorAddress,
    output logic [2:0]        oColor,
    input  logic              iWrValid,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [2:0]        iWrData,
    output logic              oWrReady,
`ifdef FB_CLEAR_EN
    input  logic              iClear,
    input  logic [2:0]        iClearColor,
`endif
    output logic              oBusy
);

    localparam int NPIX   = H_PIXELS * V_LINES;
    localparam int RAM_AW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0] PIX_COUNT = (ADDR_W + 1)'(NPIX);
    localparam logic [PTR_W:0]  FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef FB_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
`else
    typedef enum logic {IDLE} state_t;
`endif

    logic [2:0]        mem [NPIX];

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [2:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic [2:0]        head_data;
    logic              head_in_range;

    state_t            state;
    state_t            next_state;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [2:0]        ram_wdata;
    logic              rd_in_range;

`ifdef FB_CLEAR_EN
    logic [ADDR_W-1:0] clear_cnt;
    logic [ADDR_W-1:0] next_cnt;
    logic [2:0]        clear_color;
`endif

    assign oWrReady      = (count != FIFO_FULL);
    assign push          = iWrValid && oWrReady;
    assign fifo_empty    = (count == '0);
    assign head_addr     = fifo_addr[rd_ptr];
    assign head_data     = fifo_data[rd_ptr];
    assign head_in_range = ({1'b0, head_addr} < PIX_COUNT);
    assign rd_in_range   = ({1'b0, iColorAddress} < PIX_COUNT);

`ifdef FB_CLEAR_EN
    assign oBusy = (state == CLEAR);
`else
    assign oBusy = 1'b0;
`endif

    // FIFO storage needs no reset; only the pointers and count define its contents.
    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= iWrAddr;
            fifo_data[wr_ptr] <= iWrData;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
`ifdef FB_CLEAR_EN
            clear_cnt   <= '0;
            clear_color <= '0;
`endif
        end else begin
            state       <= next_state;
`ifdef FB_CLEAR_EN
            clear_cnt   <= next_cnt;
            if (state == IDLE && iClear) clear_color <= iClearColor;
`endif
        end
    end

    // A starting clear wins over draining the FIFO; out-of-range entries are popped but not written.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
`ifdef FB_CLEAR_EN
        next_cnt   = clear_cnt;
`endif
        case (state)
            IDLE: begin
`ifdef FB_CLEAR_EN
                if (iClear) next_state = CLEAR;
                else        pop = !fifo_empty;
`else
                pop = !fifo_empty;
`endif
            end
`ifdef FB_CLEAR_EN
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clear_cnt[RAM_AW-1:0];
                ram_wdata = clear_color;
                if (clear_cnt == LAST_PIX) begin
                    next_cnt   = '0;
                    next_state = IDLE;
                end else begin
                    next_cnt   = clear_cnt + 1'b1;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
        if (pop && head_in_range) begin
            ram_we    = 1'b1;
            ram_waddr = head_addr[RAM_AW-1:0];
            ram_wdata = head_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    // Same-edge read of the written address sees the old word (read-first).
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)           oColor <= '0;
        else if (rd_in_range) oColor <= mem[iColorAddress[RAM_AW-1:0]];
        else                  oColor <= '0;
    end

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer in a 40x30 configuration (1200 pixels).
// Clear scenarios are compiled only when FB_CLEAR_EN is defined.
module tb_frame_buffer;

    localparam int H    = 40;
    localparam int V    = 30;
    localparam int AW   = 11;
    localparam int NPIX = H * V;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [AW-1:0] iColorAddress = '0;
    logic [2:0]    oColor;
    logic          iWrValid = 1'b0;
    logic [AW-1:0] iWrAddr = '0;
    logic [2:0]    iWrData = '0;
    logic          oWrReady;
    logic          oBusy;
`ifdef FB_CLEAR_EN
    logic          iClear = 1'b0;
    logic [2:0]    iClearColor = '0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q [$];

    always #5 Clock = ~Clock;

    frame_buffer #(
        .H_PIXELS  (H),
        .V_LINES   (V),
        .ADDR_W    (AW),
        .FIFO_DEPTH(4)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iColorAddress(iColorAddress),
        .oColor       (oColor),
        .iWrValid     (iWrValid),
        .iWrAddr      (iWrAddr),
        .iWrData      (iWrData),
        .oWrReady     (oWrReady),
`ifdef FB_CLEAR_EN
        .iClear       (iClear),
        .iClearColor  (iClearColor),
`endif
        .oBusy        (oBusy)
    );

    task automatic push_write(input logic [AW-1:0] a, input logic [2:0] d, output logic ready);
        @(negedge Clock);
        iWrValid = 1'b1;
        iWrAddr  = a;
        iWrData  = d;
        #1 ready = oWrReady;
        @(posedge Clock);
        #1 iWrValid = 1'b0;
    endtask

    task automatic read_pixel(input logic [AW-1:0] a, output logic [2:0] got);
        @(negedge Clock);
        iColorAddress = a;
        @(posedge Clock);
        #1 got = oColor;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #100 Reset = 1'b1;
        #1;
        n_checks++;
        if (oColor !== 3'b000) begin
            n_fail++; $display("[TB] FAIL reset_color: got %b expected 000", oColor);
        end
        n_checks++;
        if (oWrReady !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", oWrReady);
        end
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", oBusy);
        end
    endtask

    task automatic test_single_write();
        logic       rdy;
        logic [2:0] got, e;
        logic [AW-1:0] addrs [3];
        addrs[0] = 11'd1000; addrs[1] = 11'd1200; addrs[2] = 11'd2047;
        push_write(11'd1000, 3'b101, rdy);
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL single_accept: got %b expected 1", rdy);
        end
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b000);
        @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            read_pixel(addrs[i], got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++; $display("[TB] FAIL single_read addr %0d: got %b expected %b", addrs[i], got, e);
            end
        end
    endtask

    task automatic test_read_first();
        logic       rdy;
        logic [2:0] got, e;
        push_write(11'd5, 3'b001, rdy);
        repeat (3) @(negedge Clock);
        push_write(11'd5, 3'b110, rdy);
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL rf_accept: got %b expected 1", rdy);
        end
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b110);
        for (int i = 0; i < 2; i++) begin
            read_pixel(11'd5, got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++; $display("[TB] FAIL read_first step %0d: got %b expected %b", i, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] wa [6];
        logic [2:0]    wd [6];
        logic [AW-1:0] ra [5];
        logic [2:0]    model [int];
        logic          rdy;
        logic [2:0]    got, e;
        wa[0] = 11'd10;   wd[0] = 3'b011;
        wa[1] = 11'd11;   wd[1] = 3'b100;
        wa[2] = 11'd10;   wd[2] = 3'b111;
        wa[3] = 11'd1200; wd[3] = 3'b001;
        wa[4] = 11'd1199; wd[4] = 3'b110;
        wa[5] = 11'd0;    wd[5] = 3'b001;
        for (int i = 0; i < 6; i++) begin
            push_write(wa[i], wd[i], rdy);
            if (int'(wa[i]) < NPIX) model[int'(wa[i])] = wd[i];
            n_checks++;
            if (rdy !== 1'b1) begin
                n_fail++; $display("[TB] FAIL b2b_accept %0d: got %b expected 1", i, rdy);
            end
        end
        repeat (3) @(negedge Clock);
        ra[0] = 11'd10; ra[1] = 11'd11; ra[2] = 11'd1199; ra[3] = 11'd0; ra[4] = 11'd1200;
        for (int i = 0; i < 5; i++)
            exp_q.push_back(model.exists(int'(ra[i])) ? model[int'(ra[i])] : 3'b000);
        for (int i = 0; i < 5; i++) begin
            read_pixel(ra[i], got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++; $display("[TB] FAIL b2b_read addr %0d: got %b expected %b", ra[i], got, e);
            end
        end
    endtask

`ifdef FB_CLEAR_EN
    task automatic start_clear(input logic [2:0] c);
        @(negedge Clock);
        iClear      = 1'b1;
        iClearColor = c;
        @(posedge Clock);
        #1 iClear = 1'b0;
    endtask

    task automatic wait_not_busy();
        for (int k = 0; k < 2 * NPIX; k++) begin
            if (!oBusy) break;
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_clear();
        int         k;
        logic [2:0] got, e;
        int         bad;
        start_clear(3'b010);
        n_checks++;
        if (oBusy !== 1'b1) begin
            n_fail++; $display("[TB] FAIL clear_busy_rise: got %b expected 1", oBusy);
        end
        for (k = 1; k <= 2 * NPIX; k++) begin
            @(negedge Clock);
            iClear      = (k == 100);
            iClearColor = 3'b111;
            @(posedge Clock);
            #1;
            if (!oBusy) break;
        end
        iClear = 1'b0;
        n_checks++;
        if (k !== NPIX) begin
            n_fail++; $display("[TB] FAIL clear_busy_len: got %0d expected %0d", k, NPIX);
        end
        bad = 0;
        for (int a = 0; a < NPIX; a++) begin
            exp_q.push_back(3'b010);
            read_pixel(AW'(a), got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                if (bad < 8) $display("[TB] FAIL clear_fill addr %0d: got %b expected %b", a, got, e);
                bad++;
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [AW-1:0] wa [5];
        logic [2:0]    wd [5];
        logic [AW-1:0] ra [4];
        logic          rdy;
        logic [2:0]    got, e;
        wa[0] = 11'd20; wd[0] = 3'b001;
        wa[1] = 11'd21; wd[1] = 3'b010;
        wa[2] = 11'd20; wd[2] = 3'b011;
        wa[3] = 11'd22; wd[3] = 3'b101;
        wa[4] = 11'd23; wd[4] = 3'b110;
        start_clear(3'b100);
        for (int i = 0; i < 5; i++) begin
            push_write(wa[i], wd[i], rdy);
            n_checks++;
            if (rdy !== (i < 4)) begin
                n_fail++; $display("[TB] FAIL full_ready push %0d: got %b expected %b", i, rdy, (i < 4));
            end
        end
        wait_not_busy();
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL full_clear_done: got %b expected 0", oBusy);
        end
        repeat (6) @(negedge Clock);
        n_checks++;
        if (oWrReady !== 1'b1) begin
            n_fail++; $display("[TB] FAIL full_drained_ready: got %b expected 1", oWrReady);
        end
        ra[0] = 11'd20; ra[1] = 11'd21; ra[2] = 11'd22; ra[3] = 11'd23;
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b100);
        for (int i = 0; i < 4; i++) begin
            read_pixel(ra[i], got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++; $display("[TB] FAIL full_read addr %0d: got %b expected %b", ra[i], got, e);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [AW-1:0] ra [5];
        logic [2:0]    got, e;
        start_clear(3'b110);
        repeat (10) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midclr_busy: got %b expected 0", oBusy);
        end
        n_checks++;
        if (oColor !== 3'b000) begin
            n_fail++; $display("[TB] FAIL midclr_color: got %b expected 000", oColor);
        end
        n_checks++;
        if (oWrReady !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midclr_ready: got %b expected 1", oWrReady);
        end
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        start_clear(3'b101);
        ra[0] = 11'd0; ra[1] = 11'd0; ra[2] = 11'd12;
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b100);
        for (int i = 0; i < 3; i++) begin
            read_pixel(ra[i], got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++; $display("[TB] FAIL restart_read %0d addr %0d: got %b expected %b", i, ra[i], got, e);
            end
        end
        wait_not_busy();
        n_checks++;
        if (oBusy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL restart_done: got %b expected 0", oBusy);
        end
        ra[3] = 11'd12; ra[4] = 11'd1199;
        exp_q.push_back(3'b101);
        exp_q.push_back(3'b101);
        for (int i = 3; i < 5; i++) begin
            read_pixel(ra[i], got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++; $display("[TB] FAIL restart_fill addr %0d: got %b expected %b", ra[i], got, e);
            end
        end
    endtask
`endif

    initial begin
        $display("[TB] frame_buffer bench start");
        test_reset();
        test_single_write();
        test_read_first();
        test_back_to_back();
`ifdef FB_CLEAR_EN
        test_clear();
        test_fifo_full();
        test_reset_mid_clear();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buffer.md
# frame_buffer

Pixel frame buffer sitting directly upstream of the VGA timing generator. It answers the VGA stage's `oColorAddress` with a 3-bit color one clock later, and accepts pixel writes from a drawing or CPU source through a small write FIFO. An optional clear engine fills the whole frame with one color. Reads and writes use separate RAM ports, so the display read path is never stalled.

## Interface
- `H_PIXELS`, 640: active pixels per line.
- `V_LINES`, 480: active lines per frame.
- `ADDR_W`, 19: pixel address width; must satisfy 2^ADDR_W ≥ H_PIXELS·V_LINES.
- `FIFO_DEPTH`, 4: write FIFO entries; power of two, ≥ 2.

Ports:
- `Clock`, in, 1: single system clock; all logic on the rising edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `iColorAddress`, in, ADDR_W: read address from the VGA stage; linear address, y·H_PIXELS + x.
- `oColor`, out, 3: registered read data {R,G,B} to the VGA stage.
- `iWrValid`, in, 1: write request.
- `iWrAddr`, in, ADDR_W: write pixel address.
- `iWrData`, in, 3: write pixel color.
- `oWrReady`, out, 1: FIFO can accept; a transfer occurs when `iWrValid` and `oWrReady` are both high.
- `iClear`, in, 1: one-cycle pulse that starts a full-frame clear. Present only with `FB_CLEAR_EN`.
- `iClearColor`, in, 3: fill color, sampled on the `iClear` cycle. Present only with `FB_CLEAR_EN`.
- `oBusy`, out, 1: clear in progress. Tied 0 without `FB_CLEAR_EN`.

## Operation
- RAM: H_PIXELS·V_LINES × 3 bits, true dual-port.
  - Port A: read-only, serves the VGA stage.
  - Port B: write-only.
  - RAM contents are not reset.
- Read path:
  - `oColor` is registered from RAM[`iColorAddress`] every cycle.
  - An address ≥ H_PIXELS·V_LINES returns 3'b000.
  - A read and write to the same address in the same cycle returns the old data (read-first).
- Write FIFO:
  - `oWrReady` = !full. It is combinational from the registered count.
  - A push and a pop in the same cycle leave the count unchanged.
  - When full, a push is refused; a pop on the same cycle still proceeds.
- Write state machine:
  - IDLE: if the FIFO is not empty, pop one entry and write RAM[addr] = data in the same cycle.
    - An address out of range is popped and discarded.
    - With `FB_CLEAR_EN`, `iClear` moves the machine to CLEAR. Clear has priority over a pop that cycle.
  - CLEAR:
    - Write RAM[cnt] = latched color, with cnt running 0 to H_PIXELS·V_LINES−1, one pixel per cycle.
    - The FIFO still accepts pushes but is not drained.
    - After the last pixel, return to IDLE.
  - `iClear` during CLEAR is ignored; no restart.
- Reset, asserted at any time:
  - State = IDLE, FIFO emptied, clear counter = 0, `oColor` = 0, `oBusy` = 0.
  - A clear in progress is aborted, leaving the frame partially filled.
- Arithmetic:
  - The clear counter is ADDR_W bits.
  - The FIFO pointers are log2(FIFO_DEPTH) bits with natural wrap, plus a count of log2(FIFO_DEPTH)+1 bits.

## Timing
- Read latency is exactly 1 cycle: an address applied before edge N appears on `oColor` after edge N.
- Write visibility:
  - A write accepted at edge N, with the FIFO empty and the machine in IDLE, is written to RAM at edge N+1.
  - A read of that address issued before edge N+2 returns the new data after edge N+2.
- Clear:
  - `iClear` sampled at edge N; `oBusy` is high from edge N.
  - The last pixel is written at edge N+H_PIXELS·V_LINES.
  - `oBusy` falls on that same edge.
- FIFO throughput: one push and one pop per cycle when not clearing.

## Configuration
- `FB_CLEAR_EN` defined:
  - `iClear`, `iClearColor`, the CLEAR state and the clear counter are compiled in.
  - `oBusy` reflects the clear.
- `FB_CLEAR_EN` undefined:
  - The ports are absent and the machine has IDLE only.
  - `oBusy` = 0 constant.
  - RAM holds whatever it powered up with, or initial contents in simulation.

## Test plan
- Reset check: hold `Reset`=0 for 100 ns, release → `oColor`=0, `oWrReady`=1, `oBusy`=0.
- Single write and readback: write addr 1000, data 3'b101; drive `iColorAddress`=1000 two cycles later → `oColor`=3'b101 one cycle after that. Address 307200 → 3'b000.
- FIFO full: with a clear running, push 5 writes → first 4 accepted, `oWrReady`=0 on the 5th. After the clear, all 4 are written in order, and the last write to a duplicate address wins.
- Clear (with `FB_CLEAR_EN`), small config H=8, V=4: pulse `iClear` with color 3'b010 → `oBusy` high for exactly 32 cycles; every address reads 3'b010.
- Reset mid-clear, H=8, V=4: assert `Reset` at cycle 10 of the clear → `oBusy`=0 immediately. The next `iClear` restarts from address 0.
- Read-first: read and write address 5 in the same cycle, old=3'b001, new=3'b110 → `oColor`=3'b001, then 3'b110 on the next read.
